// File: rtl/pciexp_comma_align_if.sv
// Lane-side bundle of the comma aligner: unaligned deserializer words in,
// symbol-framed 8b/10b words plus lock status out.
interface pciexp_comma_align_if;
    logic [9:0] raw_in;
    logic       raw_vld;
    logic [9:0] align_out;
    logic       align_vld;
    logic       sym_lock;
    logic       comma_det;
    logic       realign;

    modport master (
        output raw_in, raw_vld,
        input  align_out, align_vld, sym_lock, comma_det, realign
    );

    modport slave (
        input  raw_in, raw_vld,
        output align_out, align_vld, sym_lock, comma_det, realign
    );
endinterface

// File: rtl/pciexp_comma_align.sv
// PCIe receive-lane comma aligner: finds K28.x commas in a bit-slipped word stream,
// re-frames symbols and tracks symbol lock. Optional lock timeout: PCIEXP_CALIGN_TIMEOUT_EN.
module pciexp_comma_align #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pciexp_comma_align_if.slave  bus
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);

    if (LOCK_CNT < 1 || LOCK_CNT > 15 || LOSS_CNT < 1 || LOSS_CNT > 15 || TIMEOUT < 1) begin : g_param_check
        $error("pciexp_comma_align: parameter out of range");
    end

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [9:0]      prev;
    logic            primed;
    logic [3:0]      offset, offset_n;
    logic [GW-1:0]   good_cnt, good_n, good_inc;
    logic [BW-1:0]   bad_cnt, bad_n, bad_inc;
    logic [19:0]     window;
    logic [9:0][9:0] cand;
    logic [9:0]      hit;
    logic [3:0]      first_k;
    logic            any_hit;
    logic            cur_hit;
    logic            eval;
    logic [9:0]      sel_sym;
    logic            sel_hit;
    logic [9:0]      align_out_r;
    logic            align_vld_r;
    logic            comma_r;
    logic            realign_r;

`ifdef PCIEXP_CALIGN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   tmo_cnt, tmo_n, tmo_inc;
`endif

    // The deepest candidate (k=9) ends at bit 1; bit 0 is only framed after it moves into prev.
    assign window     = {prev, bus.raw_in};
    wire   unused_lsb = window[0];

    assign eval     = bus.raw_vld && primed;
    assign any_hit  = |hit;
    assign good_inc = (good_cnt == GW'(LOCK_CNT)) ? good_cnt : good_cnt + GW'(1);
    assign bad_inc  = (bad_cnt == BW'(LOSS_CNT)) ? bad_cnt : bad_cnt + BW'(1);
`ifdef PCIEXP_CALIGN_TIMEOUT_EN
    assign tmo_inc  = (tmo_cnt == TW'(TIMEOUT)) ? tmo_cnt : tmo_cnt + TW'(1);
`endif

    // Walk offsets from high to low so the lowest hitting k is the one left in first_k.
    always_comb begin
        cand    = '0;
        hit     = '0;
        first_k = '0;
        cur_hit = 1'b0;
        for (int k = 9; k >= 0; k--) begin
            cand[k] = window[19-k -: 10];
            hit[k]  = (window[19-k -: 7] == 7'b0011111) || (window[19-k -: 7] == 7'b1100000);
            if (hit[k]) begin
                first_k = 4'(k);
            end
            if (offset == 4'(k)) begin
                cur_hit = hit[k];
            end
        end
    end

    always_comb begin
        state_n  = state;
        offset_n = offset;
        good_n   = good_cnt;
        bad_n    = bad_cnt;
`ifdef PCIEXP_CALIGN_TIMEOUT_EN
        tmo_n    = tmo_cnt;
`endif
        if (eval) begin
            case (state)
                UNLOCK: begin
                    if (any_hit) begin
                        offset_n = first_k;
                        good_n   = GW'(1);
                        bad_n    = '0;
                        state_n  = (LOCK_CNT == 1) ? LOCKED : CHECK;
                    end
                end
                CHECK: begin
                    if (cur_hit) begin
                        good_n = good_inc;
                        if (good_inc == GW'(LOCK_CNT)) begin
                            state_n = LOCKED;
                        end
                    end else if (any_hit) begin
                        offset_n = first_k;
                        good_n   = GW'(1);
                    end
                end
                LOCKED: begin
                    if (cur_hit) begin
                        bad_n = '0;
`ifdef PCIEXP_CALIGN_TIMEOUT_EN
                        tmo_n = '0;
`endif
                    end else begin
                        if (any_hit) begin
                            bad_n = bad_inc;
                            if (bad_inc == BW'(LOSS_CNT)) begin
                                state_n = UNLOCK;
                                good_n  = '0;
                                bad_n   = '0;
                            end
                        end
`ifdef PCIEXP_CALIGN_TIMEOUT_EN
                        tmo_n = tmo_inc;
                        if (tmo_inc == TW'(TIMEOUT)) begin
                            state_n = UNLOCK;
                            good_n  = '0;
                            bad_n   = '0;
                        end
                        if (state_n == UNLOCK) begin
                            tmo_n = '0;
                        end
`endif
                    end
                end
                default: state_n = UNLOCK;
            endcase
        end
    end

    // Output framing follows this cycle's decision, so an adopted offset frames its own comma.
    always_comb begin
        sel_sym = cand[0];
        sel_hit = hit[0];
        for (int k = 1; k < 10; k++) begin
            if (offset_n == 4'(k)) begin
                sel_sym = cand[k];
                sel_hit = hit[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= UNLOCK;
            offset   <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            prev     <= '0;
            primed   <= 1'b0;
        end else begin
            state    <= state_n;
            offset   <= offset_n;
            good_cnt <= good_n;
            bad_cnt  <= bad_n;
            if (bus.raw_vld) begin
                prev   <= bus.raw_in;
                primed <= 1'b1;
            end
        end
    end

`ifdef PCIEXP_CALIGN_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_n;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_out_r <= '0;
            align_vld_r <= 1'b0;
            comma_r     <= 1'b0;
            realign_r   <= 1'b0;
        end else begin
            align_vld_r <= eval;
            comma_r     <= eval && sel_hit;
            realign_r   <= eval && (offset_n != offset);
            if (eval) begin
                align_out_r <= sel_sym;
            end
        end
    end

    assign bus.align_out = align_out_r;
    assign bus.align_vld = align_vld_r;
    assign bus.comma_det = comma_r;
    assign bus.realign   = realign_r;
    assign bus.sym_lock  = (state == LOCKED);
endmodule
